sram_2k8_access_ctrl: RTL

//  Access sequencer for one TMM2018D-class 2Kx8 static RAM. Turns a single-cycle
//  req/ack host request into CS_n / OE_n / W_n strobe sequences with programmable

---
 rtl/sram_2k8_access_ctrl.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/sram_2k8_access_ctrl.sv
// ----------------------------------------------------------------------------
// sram_2k8_access_ctrl
//
// Access sequencer for one 2Kx8 static RAM. A single-cycle req from the host
// is turned into a CS_n / OE_n / W_n strobe sequence with programmable setup,
// pulse and hold lengths. Write data is driven onto the SRAM bus and read data
// is registered into rdata. Every output comes straight from a flop.
//
// Optional feature macro: SRAM_CTRL_WAIT_EN
//   defined     : sram_wait=1 on the edge that would end STROBE keeps STROBE
//                 active (counter frozen, strobe low, read capture deferred).
//   not defined : sram_wait is ignored; timing is fixed by the parameters.
//
// Ports
//   sysclk     in   1   system clock, rising edge
//   sys_rst_n  in   1   synchronous active-low reset
//   req        in   1   host request, sampled only while busy=0
//   we         in   1   1=write, 0=read (sampled with req)
//   addr       in   AW  host address (sampled with req)
//   wdata      in   DW  host write data (sampled with req)
//   busy       out  1   access in progress
//   ack        out  1   one-cycle completion pulse
//   rdata      out  DW  last read data, valid from ack
//   sram_a     out  AW  SRAM address
//   sram_cs_n  out  1   chip select, active low
//   sram_oe_n  out  1   output enable, active low
//   sram_w_n   out  1   write strobe, active low
//   sram_d_o   out  DW  write data to SRAM
//   sram_d_oe  out  1   1 = controller drives the data bus
//   sram_d_i   in   DW  read data from SRAM
//   sram_wait  in   1   strobe-stretch request
// ----------------------------------------------------------------------------
module sram_2k8_access_ctrl #(
    parameter int AW      = 11,
    parameter int DW      = 8,
    parameter int T_SETUP = 1,
    parameter int T_PULSE = 2,
    parameter int T_HOLD  = 1
) (
    input  logic          sysclk,
    input  logic          sys_rst_n,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          ack,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] sram_a,
    output logic          sram_cs_n,
    output logic          sram_oe_n,
    output logic          sram_w_n,
    output logic [DW-1:0] sram_d_o,
    output logic          sram_d_oe,
    input  logic [DW-1:0] sram_d_i,
    input  logic          sram_wait
);

    // state   | meaning
    // --------+--------------------------------------------------------------
    // IDLE    | waiting for req; cs_n high, bus released
    // SETUP   | cs_n low, address (and write data) settling before strobe
    // STROBE  | oe_n (read) or w_n (write) low
    // HOLD    | strobe released, cs_n/address/data held
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    if (T_SETUP < 1 || T_PULSE < 1 || T_HOLD < 1) begin : g_bad_timing
        $error("sram_2k8_access_ctrl: T_SETUP, T_PULSE and T_HOLD must all be >= 1");
    end

    // Counter holds (phase length - 1) and counts down to zero.
    localparam int TMAX_SP = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int TMAX    = (TMAX_SP > T_HOLD) ? TMAX_SP : T_HOLD;
    localparam int CW      = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_PULSE = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_we;
    logic            r_busy;
    logic            r_ack;
    logic [DW-1:0]   r_rdata;
    logic [AW-1:0]   r_a;
    logic            r_cs_n;
    logic            r_oe_n;
    logic            r_w_n;
    logic [DW-1:0]   r_d_o;
    logic            r_d_oe;

    state_t          w_state_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_we_nxt;
    logic            w_busy_nxt;
    logic            w_ack_nxt;
    logic [DW-1:0]   w_rdata_nxt;
    logic [AW-1:0]   w_a_nxt;
    logic            w_cs_n_nxt;
    logic            w_oe_n_nxt;
    logic            w_w_n_nxt;
    logic [DW-1:0]   w_d_o_nxt;
    logic            w_d_oe_nxt;
    logic            w_stall;

`ifdef SRAM_CTRL_WAIT_EN
    assign w_stall = sram_wait;
`else
    logic w_unused_wait;
    assign w_unused_wait = sram_wait;
    assign w_stall       = 1'b0;
`endif

    always_ff @(posedge sysclk) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
            r_a     <= '0;
            r_cs_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_w_n   <= 1'b1;
            r_d_o   <= '0;
            r_d_oe  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_we    <= w_we_nxt;
            r_busy  <= w_busy_nxt;
            r_ack   <= w_ack_nxt;
            r_rdata <= w_rdata_nxt;
            r_a     <= w_a_nxt;
            r_cs_n  <= w_cs_n_nxt;
            r_oe_n  <= w_oe_n_nxt;
            r_w_n   <= w_w_n_nxt;
            r_d_o   <= w_d_o_nxt;
            r_d_oe  <= w_d_oe_nxt;
        end
    end

    // Computes the next value of every registered output, so strobes change
    // exactly on the edge where the state changes.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_we_nxt    = r_we;
        w_busy_nxt  = r_busy;
        w_ack_nxt   = 1'b0;
        w_rdata_nxt = r_rdata;
        w_a_nxt     = r_a;
        w_cs_n_nxt  = r_cs_n;
        w_oe_n_nxt  = r_oe_n;
        w_w_n_nxt   = r_w_n;
        w_d_o_nxt   = r_d_o;
        w_d_oe_nxt  = r_d_oe;

        unique case (r_state)
            IDLE: begin
                if (req) begin
                    w_state_nxt = SETUP;
                    w_cnt_nxt   = LD_SETUP;
                    w_we_nxt    = we;
                    w_busy_nxt  = 1'b1;
                    w_a_nxt     = addr;
                    w_cs_n_nxt  = 1'b0;
                    w_oe_n_nxt  = 1'b1;
                    w_w_n_nxt   = 1'b1;
                    w_d_oe_nxt  = we;
                    if (we) begin
                        w_d_o_nxt = wdata;
                    end
                end
            end
            SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = STROBE;
                    w_cnt_nxt   = LD_PULSE;
                    w_oe_n_nxt  = r_we;
                    w_w_n_nxt   = !r_we;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            STROBE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end else if (!w_stall) begin
                    // Read data is taken on the edge that releases oe_n.
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = LD_HOLD;
                    w_oe_n_nxt  = 1'b1;
                    w_w_n_nxt   = 1'b1;
                    if (!r_we) begin
                        w_rdata_nxt = sram_d_i;
                    end
                end
            end
            HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                    w_ack_nxt   = 1'b1;
                    w_cs_n_nxt  = 1'b1;
                    w_d_oe_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy      = r_busy;
    assign ack       = r_ack;
    assign rdata     = r_rdata;
    assign sram_a    = r_a;
    assign sram_cs_n = r_cs_n;
    assign sram_oe_n = r_oe_n;
    assign sram_w_n  = r_w_n;
    assign sram_d_o  = r_d_o;
    assign sram_d_oe = r_d_oe;

endmodule
